// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
// Used by pc_redirect_latch and pc_gen_unit.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      EMPTY     = 2'd0,
      BR_PEND   = 2'd1,
      TRAP_PEND = 2'd2
   } pend_state_e;

   localparam int unsigned MAX_XLEN = 64;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

   // Mask of the low target bits that must be zero for a legal fetch address.
   function automatic logic [MAX_XLEN-1:0] align_mask(input int unsigned align_bits);
      return (MAX_XLEN'(1) << align_bits) - MAX_XLEN'(1);
   endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a redirect that arrives while fetch is stalled until the stall releases.
// A trap entry can only be replaced by a newer trap; a branch entry by anything.
module pc_redirect_latch
   import pc_gen_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            trap_req_i,
   input  logic [XLEN-1:0] trap_vec_i,
   input  logic            br_req_i,
   input  logic [XLEN-1:0] br_target_i,
   output logic            pend_o,
   output logic            pend_trap_o,
   output logic            pend_br_o,
   output logic [XLEN-1:0] target_o
);

   pend_state_e     state_q, state_d;
   logic [XLEN-1:0] target_q, target_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
      end
   end

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      if (!stall_i) begin
         state_d = EMPTY;
      end else if (trap_req_i) begin
         state_d  = TRAP_PEND;
         target_d = trap_vec_i;
      end else if (br_req_i && (state_q != TRAP_PEND)) begin
         state_d  = BR_PEND;
         target_d = br_target_i;
      end
   end

   always_comb begin
      pend_o      = (state_q != EMPTY);
      pend_trap_o = (state_q == TRAP_PEND);
      pend_br_o   = (state_q == BR_PEND);
      target_o    = target_q;
   end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC register and next-PC select with stall-safe redirect latching.
// Optional PC_GEN_PERF_EN adds saturating redirect and stall counters.
module pc_gen_unit
   import pc_gen_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
   parameter int unsigned     ALIGN_BITS   = 2,
   parameter int unsigned     INC          = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            StallF,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic            TrapReq,
   input  logic [XLEN-1:0] TrapVec,
   output logic [XLEN-1:0] PCF,
   output logic [XLEN-1:0] PCPlus4F,
`ifdef PC_GEN_PERF_EN
   output logic [31:0]     RedirCount,
   output logic [31:0]     StallCount,
`endif
   output logic            RedirPendF,
   output logic            MisalignF
);

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(ALIGN_BITS));
   localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);

   logic [XLEN-1:0] pc_q, pc_d;
   logic            misalign_q, misalign_d;
   logic            tgt_misaligned;
   logic [XLEN-1:0] br_target_eff;
   logic            pend, pend_trap, pend_br;
   logic [XLEN-1:0] pend_target;

   // A misaligned branch target is diverted to the trap vector before it is
   // either applied or latched, so the latch never holds an illegal address.
   always_comb begin
      tgt_misaligned = |(PCTargetE & ALIGN_MASK);
      br_target_eff  = tgt_misaligned ? TRAP_VECTOR : PCTargetE;
      misalign_d     = PCSrcE && !TrapReq && tgt_misaligned;
   end

   pc_redirect_latch #(
      .XLEN (XLEN)
   ) u_redirect_latch (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_i     (StallF),
      .trap_req_i  (TrapReq),
      .trap_vec_i  (TrapVec),
      .br_req_i    (PCSrcE),
      .br_target_i (br_target_eff),
      .pend_o      (pend),
      .pend_trap_o (pend_trap),
      .pend_br_o   (pend_br),
      .target_o    (pend_target)
   );

   // A fresh branch outranks a stale pending branch, but not a pending trap.
   always_comb begin
      pc_d = pc_q;
      if (!StallF) begin
         if (TrapReq)        pc_d = TrapVec;
         else if (pend_trap) pc_d = pend_target;
         else if (PCSrcE)    pc_d = br_target_eff;
         else if (pend_br)   pc_d = pend_target;
         else                pc_d = PCPlus4F;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VECTOR;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   assign PCF        = pc_q;
   assign PCPlus4F   = pc_q + INC_W;
   assign RedirPendF = pend;
   assign MisalignF  = misalign_q;

`ifdef PC_GEN_PERF_EN
   logic [31:0] redir_cnt_q, redir_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        redir_apply;

   // A pending redirect is counted once, on the cycle it is applied.
   always_comb begin
      redir_apply = !StallF && (TrapReq || pend || PCSrcE);
      redir_cnt_d = redir_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (redir_apply && (redir_cnt_q != '1)) redir_cnt_d = redir_cnt_q + 32'd1;
      if (StallF && (stall_cnt_q != '1))      stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redir_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         redir_cnt_q <= redir_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign RedirCount = redir_cnt_q;
   assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: table-driven vectors through a scoreboard
// queue, a second instance with ALIGN_BITS=1, and a reset-mid-stall sequence.
module tb_pc_gen_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_f = 1'b0;
   logic        pc_src_e = 1'b0;
   logic [31:0] pc_target_e = '0;
   logic        trap_req = 1'b0;
   logic [31:0] trap_vec = '0;

   logic [31:0] pcf, pc_plus4f;
   logic        redir_pend, misalign;
   logic [31:0] pcf_a1, pc_plus4f_a1;
   logic        redir_pend_a1, misalign_a1;
`ifdef PC_GEN_PERF_EN
   logic [31:0] redir_count, stall_count, redir_count_a1, stall_count_a1;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_gen_unit u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .StallF     (stall_f),
      .PCSrcE     (pc_src_e),
      .PCTargetE  (pc_target_e),
      .TrapReq    (trap_req),
      .TrapVec    (trap_vec),
      .PCF        (pcf),
      .PCPlus4F   (pc_plus4f),
`ifdef PC_GEN_PERF_EN
      .RedirCount (redir_count),
      .StallCount (stall_count),
`endif
      .RedirPendF (redir_pend),
      .MisalignF  (misalign)
   );

   pc_gen_unit #(
      .ALIGN_BITS (1)
   ) u_dut_a1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .StallF     (stall_f),
      .PCSrcE     (pc_src_e),
      .PCTargetE  (pc_target_e),
      .TrapReq    (trap_req),
      .TrapVec    (trap_vec),
      .PCF        (pcf_a1),
      .PCPlus4F   (pc_plus4f_a1),
`ifdef PC_GEN_PERF_EN
      .RedirCount (redir_count_a1),
      .StallCount (stall_count_a1),
`endif
      .RedirPendF (redir_pend_a1),
      .MisalignF  (misalign_a1)
   );

   typedef struct {
      string       name;
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      logic        trap;
      logic [31:0] tvec;
      logic [31:0] exp_pc;
      logic        exp_pend;
      logic        exp_mis;
      logic        a1_chk;
      logic [31:0] a1_pc;
      logic        a1_mis;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic        pend;
      logic        mis;
      logic        a1_chk;
      logic [31:0] a1_pc;
      logic        a1_mis;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic stall, input logic br, input logic [31:0] tgt,
                      input logic trap, input logic [31:0] tvec, input logic [31:0] exp_pc,
                      input logic exp_pend, input logic exp_mis, input logic a1_chk,
                      input logic [31:0] a1_pc, input logic a1_mis);
      vec_t v;
      v.name = name; v.stall = stall; v.br = br; v.tgt = tgt; v.trap = trap; v.tvec = tvec;
      v.exp_pc = exp_pc; v.exp_pend = exp_pend; v.exp_mis = exp_mis;
      v.a1_chk = a1_chk; v.a1_pc = a1_pc; v.a1_mis = a1_mis;
      vecs.push_back(v);
   endtask

   task automatic compare_head();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard: got empty queue expected an entry");
         return;
      end
      e = sb_q.pop_front();
      check({e.name, " PCF"},        pcf,                e.pc);
      check({e.name, " PCPlus4F"},   pc_plus4f,          e.pc + 32'd4);
      check({e.name, " RedirPendF"}, 32'(redir_pend),    32'(e.pend));
      check({e.name, " MisalignF"},  32'(misalign),      32'(e.mis));
      if (e.a1_chk) begin
         check({e.name, " a1 PCF"},       pcf_a1,           e.a1_pc);
         check({e.name, " a1 MisalignF"}, 32'(misalign_a1), 32'(e.a1_mis));
      end
   endtask

   // Inputs are driven on the falling edge; results are sampled one falling edge later.
   task automatic run_vec(input vec_t v);
      exp_t e;
      stall_f     = v.stall;
      pc_src_e    = v.br;
      pc_target_e = v.tgt;
      trap_req    = v.trap;
      trap_vec    = v.tvec;
      e.name = v.name; e.pc = v.exp_pc; e.pend = v.exp_pend; e.mis = v.exp_mis;
      e.a1_chk = v.a1_chk; e.a1_pc = v.a1_pc; e.a1_mis = v.a1_mis;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      compare_head();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      //   name          stall br  tgt            trap tvec      exp_pc         pend mis a1 a1_pc     a1_mis
      add("seq0",        0,    0,  32'h0,         0,   32'h0,    32'h0000_0004, 0,   0,  1, 32'h0004, 0);
      add("seq1",        0,    0,  32'h0,         0,   32'h0,    32'h0000_0008, 0,   0,  0, 32'h0,    0);
      add("seq2",        0,    0,  32'h0,         0,   32'h0,    32'h0000_000C, 0,   0,  0, 32'h0,    0);
      add("seq3",        0,    0,  32'h0,         0,   32'h0,    32'h0000_0010, 0,   0,  0, 32'h0,    0);
      add("branch",      0,    1,  32'h200,       0,   32'h0,    32'h0000_0200, 0,   0,  0, 32'h0,    0);
      add("after_br",    0,    0,  32'h0,         0,   32'h0,    32'h0000_0204, 0,   0,  0, 32'h0,    0);
      add("stall_br",    1,    1,  32'h300,       0,   32'h0,    32'h0000_0204, 1,   0,  0, 32'h0,    0);
      add("stall_hold1", 1,    0,  32'h0,         0,   32'h0,    32'h0000_0204, 1,   0,  0, 32'h0,    0);
      add("stall_hold2", 1,    0,  32'h0,         0,   32'h0,    32'h0000_0204, 1,   0,  0, 32'h0,    0);
      add("release_br",  0,    0,  32'h0,         0,   32'h0,    32'h0000_0300, 0,   0,  0, 32'h0,    0);
      add("after_rel",   0,    0,  32'h0,         0,   32'h0,    32'h0000_0304, 0,   0,  0, 32'h0,    0);
      add("stall_trap",  1,    0,  32'h0,         1,   32'h80,   32'h0000_0304, 1,   0,  0, 32'h0,    0);
      add("br_no_ovwr",  1,    1,  32'h400,       0,   32'h0,    32'h0000_0304, 1,   0,  0, 32'h0,    0);
      add("release_trp", 0,    0,  32'h0,         0,   32'h0,    32'h0000_0080, 0,   0,  0, 32'h0,    0);
      add("trap_vs_br",  0,    1,  32'h500,       1,   32'h90,   32'h0000_0090, 0,   0,  0, 32'h0,    0);
      add("stall_br2",   1,    1,  32'h600,       0,   32'h0,    32'h0000_0090, 1,   0,  0, 32'h0,    0);
      add("newer_br",    0,    1,  32'h700,       0,   32'h0,    32'h0000_0700, 0,   0,  0, 32'h0,    0);
      add("stall_trap2", 1,    0,  32'h0,         1,   32'hA0,   32'h0000_0700, 1,   0,  0, 32'h0,    0);
      add("pend_trp_win",0,    1,  32'h800,       0,   32'h0,    32'h0000_00A0, 0,   0,  0, 32'h0,    0);
      add("stall_br3",   1,    1,  32'h900,       0,   32'h0,    32'h0000_00A0, 1,   0,  0, 32'h0,    0);
      add("br_ovwr_br",  1,    1,  32'h940,       0,   32'h0,    32'h0000_00A0, 1,   0,  0, 32'h0,    0);
      add("release_br2", 0,    0,  32'h0,         0,   32'h0,    32'h0000_0940, 0,   0,  1, 32'h0940, 0);
      add("misalign2",   0,    1,  32'h102,       0,   32'h0,    32'h0000_0100, 0,   1,  1, 32'h0102, 0);
      add("mis_pulse",   0,    0,  32'h0,         0,   32'h0,    32'h0000_0104, 0,   0,  1, 32'h0106, 0);
      add("stall_mis",   1,    1,  32'h206,       0,   32'h0,    32'h0000_0104, 1,   1,  1, 32'h0106, 0);
      add("rel_mis",     0,    0,  32'h0,         0,   32'h0,    32'h0000_0100, 0,   0,  1, 32'h0206, 0);
      add("misalign1",   0,    1,  32'h101,       0,   32'h0,    32'h0000_0100, 0,   1,  1, 32'h0100, 1);
      add("after_mis1",  0,    0,  32'h0,         0,   32'h0,    32'h0000_0104, 0,   0,  1, 32'h0104, 0);
      add("br_high",     0,    1,  32'hFFFF_FFF8, 0,   32'h0,    32'hFFFF_FFF8, 0,   0,  0, 32'h0,    0);
      add("near_wrap",   0,    0,  32'h0,         0,   32'h0,    32'hFFFF_FFFC, 0,   0,  0, 32'h0,    0);
      add("wrap",        0,    0,  32'h0,         0,   32'h0,    32'h0000_0000, 0,   0,  0, 32'h0,    0);
      add("trapvec_odd", 0,    0,  32'h0,         1,   32'h2,    32'h0000_0002, 0,   0,  1, 32'h0002, 0);
      add("after_odd",   0,    0,  32'h0,         0,   32'h0,    32'h0000_0006, 0,   0,  0, 32'h0,    0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset PCF",        pcf,             32'h0);
      check("reset RedirPendF", 32'(redir_pend), 32'h0);
      check("reset MisalignF",  32'(misalign),   32'h0);
      rst_n = 1'b1;
      check("post-release PCF",      pcf,       32'h0);
      check("post-release PCPlus4F", pc_plus4f, 32'h4);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset asserted while a branch is pending: it must be discarded.
      begin
         vec_t v;
         v.name = "rst_stall_br"; v.stall = 1; v.br = 1; v.tgt = 32'h500; v.trap = 0; v.tvec = 0;
         v.exp_pc = 32'h6; v.exp_pend = 1; v.exp_mis = 0; v.a1_chk = 0; v.a1_pc = 0; v.a1_mis = 0;
         run_vec(v);
      end
      pc_src_e = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async rst PCF",        pcf,             32'h0);
      check("async rst RedirPendF", 32'(redir_pend), 32'h0);
      check("async rst MisalignF",  32'(misalign),   32'h0);
      @(negedge clk);
      rst_n   = 1'b1;
      stall_f = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst discard PCF",        pcf,             32'h4);
      check("rst discard RedirPendF", 32'(redir_pend), 32'h0);

      check("scoreboard drained", 32'(sb_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
